op_issue_ctrl: RTL and testbench

Command-side initiator for the floating-point operation units that take four operands (e.g. the a/b + c/d unit). It queues operand quadruples from the RoCC command decoder and issues them one at a time over the STB/BUSY handshake. It collects the unit's result over the same handshake and returns it, tagged, to the RoCC response path. An optional watchdog guarantees a response even if the operation unit never completes.

---
 rtl/op_issue_pkg.sv | 19 +
 rtl/op_issue_fifo.sv | 53 +++++
 rtl/op_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_op_issue_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_issue_pkg.sv
// Shared types and constants for the four-operand operation-unit issue controller.
// Holds the FSM encoding, the timeout response value and the watchdog counter width helper.
package op_issue_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t ISSUE    = 2'd1;
    localparam state_t WAIT_RES = 2'd2;
    localparam state_t RESP     = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Width needed for a counter that must be able to hold values 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/op_issue_fifo.sv
// Synchronous FIFO of W-bit entries, DEPTH a power of two; head is visible combinationally on rdata.
// Pushes while full and pops while empty are ignored; storage is not reset, pointers and count are.
module op_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_issue_ctrl.sv
// Queues operand quadruples and issues them one at a time to a four-operand FP unit, returning tagged results.
// Optional watchdog (macro OP_ISSUE_TIMEOUT_EN) answers with a QNAN error response and swallows the late result.
module op_issue_ctrl
    import op_issue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_STB,
    output logic                     cmd_BUSY,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [31:0]              cmd_c,
    input  logic [31:0]              cmd_d,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     op_input_STB,
    input  logic                     op_BUSY,
    output logic [31:0]              op_a,
    output logic [31:0]              op_b,
    output logic [31:0]              op_c,
    output logic [31:0]              op_d,
    input  logic                     op_output_STB,
    input  logic [31:0]              op_result,
    output logic                     op_output_module_BUSY,
    output logic                     resp_STB,
    input  logic                     resp_BUSY,
    output logic [31:0]              resp_data,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     resp_err,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int EW = 4 * 32 + TAG_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("op_issue_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic [EW-1:0]    head;
    logic             fifo_empty;
    logic             do_pop;
    logic             drain;
    logic             timeout;

    op_issue_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_STB),
        .wdata ({cmd_tag, cmd_d, cmd_c, cmd_b, cmd_a}),
        .pop   (do_pop),
        .rdata (head),
        .count (q_count),
        .full  (cmd_BUSY),
        .empty (fifo_empty)
    );

    assign do_pop                = (state == IDLE) && !fifo_empty && !drain;
    assign op_input_STB          = (state == ISSUE);
    assign resp_STB              = (state == RESP);
    assign op_output_module_BUSY = !((state == WAIT_RES) || drain);

`ifdef OP_ISSUE_TIMEOUT_EN
    localparam int                CNTW    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNTW-1:0]   TO_LAST = CNTW'(TIMEOUT_CYC - 1);

    logic [CNTW-1:0] to_cnt;
    logic            drain_q;
    logic            err_q;

    // A result arriving on the very edge the limit is hit still wins over the timeout.
    assign timeout  = (state == WAIT_RES) && !op_output_STB && (to_cnt == TO_LAST);
    assign drain    = drain_q;
    assign resp_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE)         to_cnt <= '0;
            else if (state == WAIT_RES) to_cnt <= to_cnt + 1'b1;

            if (timeout)                     drain_q <= 1'b1;
            else if (drain_q && op_output_STB) drain_q <= 1'b0;

            if (timeout)                                  err_q <= 1'b1;
            else if ((state == WAIT_RES) && op_output_STB) err_q <= 1'b0;
        end
    end
`else
    assign timeout  = 1'b0;
    assign drain    = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            op_d      <= '0;
            tag_q     <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        op_a  <= head[31:0];
                        op_b  <= head[63:32];
                        op_c  <= head[95:64];
                        op_d  <= head[127:96];
                        tag_q <= head[EW-1:128];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!op_BUSY) state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (op_output_STB) begin
                        resp_data <= op_result;
                        resp_tag  <= tag_q;
                        state     <= RESP;
                    end else if (timeout) begin
                        resp_data <= QNAN;
                        resp_tag  <= tag_q;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (!resp_BUSY) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_issue_ctrl.sv
// Randomised scoreboard bench for op_issue_ctrl with a behavioural a/b+c/d operation unit.
// Expected responses are queued at command acceptance and checked by an independent response monitor.
module tb_op_issue_ctrl;
    import op_issue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;
    localparam int TO_CYC = 16;
`ifdef OP_ISSUE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_STB;
    logic               cmd_BUSY;
    logic [31:0]        cmd_a, cmd_b, cmd_c, cmd_d;
    logic [TAG_W-1:0]   cmd_tag;
    logic               op_input_STB;
    logic               op_BUSY;
    logic [31:0]        op_a, op_b, op_c, op_d;
    logic               op_output_STB;
    logic [31:0]        op_result;
    logic               op_output_module_BUSY;
    logic               resp_STB;
    logic               resp_BUSY;
    logic [31:0]        resp_data;
    logic [TAG_W-1:0]   resp_tag;
    logic               resp_err;
    logic [$clog2(DEPTH):0] q_count;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   issue_log[$];
    int   res_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   unit_abort = 1'b0;
    bit   unit_busy  = 1'b0;
    bit   force_busy = 1'b0;

    assign op_BUSY = unit_busy | force_busy;

    op_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_STB               (cmd_STB),
        .cmd_BUSY              (cmd_BUSY),
        .cmd_a                 (cmd_a),
        .cmd_b                 (cmd_b),
        .cmd_c                 (cmd_c),
        .cmd_d                 (cmd_d),
        .cmd_tag               (cmd_tag),
        .op_input_STB          (op_input_STB),
        .op_BUSY               (op_BUSY),
        .op_a                  (op_a),
        .op_b                  (op_b),
        .op_c                  (op_c),
        .op_d                  (op_d),
        .op_output_STB         (op_output_STB),
        .op_result             (op_result),
        .op_output_module_BUSY (op_output_module_BUSY),
        .resp_STB              (resp_STB),
        .resp_BUSY             (resp_BUSY),
        .resp_data             (resp_data),
        .resp_tag              (resp_tag),
        .resp_err              (resp_err),
        .q_count               (q_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Normal single-precision values only; adequate for the operands used here.
    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r_in);
        real  r;
        logic s;
        int   e;
        r = r_in;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        if (s) r = -r;
        e = 127;
        while (r >= 2.0 && e < 254) begin r = r / 2.0; e++; end
        while (r < 1.0 && e > 1) begin r = r * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((r - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] calc(input logic [31:0] a, b, c, d);
        return r2f(f2r(a) / f2r(b) + f2r(c) / f2r(d));
    endfunction

    function automatic logic [31:0] rnd_op();
        return r2f(real'($urandom_range(1, 64)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_cmd_BUSY"}, 32'(cmd_BUSY), 32'd0);
        chk({p, "_op_input_STB"}, 32'(op_input_STB), 32'd0);
        chk({p, "_op_a"}, op_a, 32'd0);
        chk({p, "_op_b"}, op_b, 32'd0);
        chk({p, "_op_c"}, op_c, 32'd0);
        chk({p, "_op_d"}, op_d, 32'd0);
        chk({p, "_op_out_mod_BUSY"}, 32'(op_output_module_BUSY), 32'd1);
        chk({p, "_resp_STB"}, 32'(resp_STB), 32'd0);
        chk({p, "_resp_data"}, resp_data, 32'd0);
        chk({p, "_resp_tag"}, 32'(resp_tag), 32'd0);
        chk({p, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({p, "_q_count"}, 32'(q_count), 32'd0);
    endtask

    // Reference model: each accepted command yields exactly one response, in order; an operation
    // whose unit latency exceeds the watchdog limit is answered with QNAN and the error flag.
    task automatic send_cmd(input logic [31:0] a, b, c, d, input logic [TAG_W-1:0] tag,
                            input int lat, input bit fixed, input logic [31:0] fixed_val);
        exp_t e;
        int   n;
        cmd_STB = 1'b1;
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d; cmd_tag = tag;
        n = 0;
        @(negedge clk);
        while (cmd_BUSY && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (cmd_BUSY) begin
            expire("cmd_accept");
        end else begin
            e.err  = TO_EN && (lat > TO_CYC);
            e.data = e.err ? QNAN : (fixed ? fixed_val : calc(a, b, c, d));
            e.tag  = tag;
            exp_q.push_back(e);
            lat_q.push_back(lat);
        end
        @(posedge clk);
        #1;
        cmd_STB = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) expire(name);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Behavioural operation unit: result appears 'lat' edges after the issue edge.
    initial begin
        logic [31:0] res;
        int          lat;
        int          n;
        bit          aborted;
        op_output_STB = 1'b0;
        op_result     = 32'd0;
        forever begin
            @(negedge clk);
            if (rst && op_input_STB && !op_BUSY) begin
                res = calc(op_a, op_b, op_c, op_d);
                lat = (lat_q.size() != 0) ? lat_q.pop_front() : 10;
                issue_log.push_back(cyc);
                @(posedge clk);
                #1;
                unit_busy = 1'b1;
                aborted   = 1'b0;
                for (int i = 1; i < lat; i++) begin
                    @(posedge clk);
                    if (unit_abort) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1;
                    op_result     = res;
                    op_output_STB = 1'b1;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (op_output_module_BUSY && n < 300);
                    if (op_output_module_BUSY) expire("unit_result_accept");
                    else res_log.push_back(cyc);
                    @(posedge clk);
                    #1;
                    op_output_STB = 1'b0;
                end
                unit_busy = 1'b0;
            end
        end
    end

    // Response monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && resp_STB && !resp_BUSY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got data %h tag %0d err %0d, required no response",
                         resp_data, resp_tag, resp_err);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_tag", 32'(resp_tag), 32'(e.tag));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    initial begin
        logic [31:0] ha, hb, hc, hd, ra;
        bit          stable;
        bit          rdone;
        int          n;
        int          k;

        rst = 1'b0;
        cmd_STB = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_d = '0; cmd_tag = '0;
        resp_BUSY = 1'b0;
        #12;
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed single op: 6/2 + 1/4 = 3.25
        send_cmd(32'h40C00000, 32'h40000000, 32'h3F800000, 32'h40800000, 5'd5, 10, 1'b1, 32'h40500000);
        @(negedge clk);
        chk("issue_stb_edge1", 32'(op_input_STB), 32'd0);
        @(negedge clk);
        chk("issue_stb_edge2", 32'(op_input_STB), 32'd1);
        wait_drain("drain_single");

        // Issue held off by op_BUSY
        force_busy = 1'b1;
        ra = rnd_op();
        send_cmd(ra, rnd_op(), rnd_op(), rnd_op(), 5'd7, 4, 1'b0, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_input_STB && n < 20);
        if (!op_input_STB) expire("hold_wait_stb");
        chk("hold_op_a", op_a, ra);
        ha = op_a; hb = op_b; hc = op_c; hd = op_d;
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (!op_input_STB || op_a !== ha || op_b !== hb || op_c !== hc || op_d !== hd) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        @(negedge clk);
        chk("hold_stb_before_xfer", 32'(op_input_STB), 32'd1);
        @(negedge clk);
        chk("hold_stb_after_xfer", 32'(op_input_STB), 32'd0);
        wait_drain("drain_hold");

        // Five back-to-back commands against a stalled response port
        resp_BUSY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), TAG_W'(i), 3, 1'b0, 32'd0);
        end
        @(negedge clk);
        chk("full_q_count", 32'(q_count), 32'd4);
        chk("full_cmd_BUSY", 32'(cmd_BUSY), 32'd1);
        repeat (10) @(negedge clk);
        chk("full_resp_held", 32'(resp_STB), 32'd1);
        chk("full_q_hold", 32'(q_count), 32'd4);
        @(posedge clk);
        #1;
        resp_BUSY = 1'b0;
        wait_drain("drain_full");

        // Random traffic with random response backpressure
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), TAG_W'($urandom_range(0, 31)),
                             int'($urandom_range(1, 12)), 1'b0, 32'd0);
                    k = int'($urandom_range(0, 3));
                    if (k > 0) begin
                        repeat (k) @(posedge clk);
                        #1;
                    end
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    resp_BUSY = ($urandom_range(0, 3) == 0);
                end
            end
        join
        resp_BUSY = 1'b0;
        wait_drain("drain_random");

`ifdef OP_ISSUE_TIMEOUT_EN
        // Unit never answers in time; the late result must be swallowed before the next issue
        issue_log.delete();
        res_log.delete();
        send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 5'd9, 40, 1'b0, 32'd0);
        send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 5'd10, 5, 1'b0, 32'd0);
        wait_drain("drain_timeout");
        chk("late_result_count", 32'(res_log.size()), 32'd2);
        if (res_log.size() == 2 && issue_log.size() == 2)
            chk("issue_after_late", 32'(issue_log[1] > res_log[0]), 32'd1);
`endif

        // Reset while an operation is in flight with two more queued
        send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 5'd1, 1000, 1'b0, 32'd0);
        send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 5'd2, 1000, 1'b0, 32'd0);
        send_cmd(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 5'd3, 1000, 1'b0, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (op_output_module_BUSY && n < 20);
        if (op_output_module_BUSY) expire("rst_wait_res");
        chk("rst_pre_q_count", 32'(q_count), 32'd2);
        #2;
        rst = 1'b0;
        unit_abort = 1'b1;
        exp_q.delete();
        lat_q.delete();
        #1;
        check_reset("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        unit_abort = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_q_count", 32'(q_count), 32'd0);
        chk("post_rst_op_input_STB", 32'(op_input_STB), 32'd0);
        chk("post_rst_resp_STB", 32'(resp_STB), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
